// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchroniser, debouncer, and press/release/long-press strobes with a wrapping press counter.
// The release strobe is named release_pulse because "release" is a reserved word in SystemVerilog.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000,
    parameter bit INVERT          = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       btn_level,
    output logic       press,
    output logic       release_pulse,
    output logic       long_press,
    output logic [7:0] press_count
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    logic          pad;
    logic          s1_reg;
    logic          s2_reg;
    logic [DW-1:0] db_ctr_reg;
    logic          level_reg;
    logic          level_change;
    logic          level_rise;
    logic          level_fall;

    state_t        state_reg;
    logic [HW-1:0] hold_ctr_reg;
    logic          press_reg;
    logic          release_reg;
    logic          long_reg;
    logic [7:0]    count_reg;

    // Normalise polarity before synchronising so everything downstream sees 1 = pressed.
    assign pad = INVERT ? ~btn : btn;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= pad;
            s2_reg <= s1_reg;
        end
    end

    // Counter only runs while the synchronised sample disagrees with the accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_ctr_reg <= '0;
            level_reg  <= 1'b0;
        end else if (s2_reg == level_reg) begin
            db_ctr_reg <= '0;
        end else if (db_ctr_reg == DB_LAST) begin
            db_ctr_reg <= '0;
            level_reg  <= s2_reg;
        end else begin
            db_ctr_reg <= db_ctr_reg + 1'b1;
        end
    end

    // The FSM reacts to the acceptance event itself so its strobes land on the same edge as btn_level.
    assign level_change = (s2_reg != level_reg) && (db_ctr_reg == DB_LAST);
    assign level_rise   = level_change && s2_reg;
    assign level_fall   = level_change && !s2_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            hold_ctr_reg <= '0;
            press_reg    <= 1'b0;
            release_reg  <= 1'b0;
            long_reg     <= 1'b0;
            count_reg    <= 8'd0;
        end else begin
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            long_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    hold_ctr_reg <= '0;
                    if (level_rise) begin
                        state_reg <= PRESSED;
                        press_reg <= 1'b1;
                        count_reg <= count_reg + 8'd1;
                    end
                end
                PRESSED: begin
                    // A release on the would-be long-press edge takes priority.
                    if (level_fall) begin
                        state_reg    <= IDLE;
                        release_reg  <= 1'b1;
                        hold_ctr_reg <= '0;
                    end else if (hold_ctr_reg == HOLD_LAST) begin
                        state_reg <= LONG;
                        long_reg  <= 1'b1;
                    end else begin
                        hold_ctr_reg <= hold_ctr_reg + 1'b1;
                    end
                end
                LONG: begin
                    if (level_fall) begin
                        state_reg    <= IDLE;
                        release_reg  <= 1'b1;
                        hold_ctr_reg <= '0;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    hold_ctr_reg <= '0;
                end
            endcase
        end
    end

    assign btn_level     = level_reg;
    assign press         = press_reg;
    assign release_pulse = release_reg;
    assign long_press    = long_reg;
    assign press_count   = count_reg;

endmodule
